regfile_sb: RTL and testbench

//   Parametrised integer register file for the pipelined femtoRV32 core. It has
//   two combinational read ports with write-through bypass, a hardwired-zero

---
 rtl/regfile_sb.sv | 115 +++++++++++
 tb/tb_regfile_sb.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Integer register file: two combinational read ports with write-through bypass, hardwired x0, busy scoreboard.
// Latency: reads 0 cycles, writes visible next cycle (same cycle via bypass); after reset a sweep clears one entry per cycle.
// Backpressure: none; ready stays low during the sweep and wr_en/issue_en/flush are ignored until then.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_rd,
    input  logic            flush,
    output logic            ready
);
    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [AW:0] LAST = (AW+1)'(NREGS - 1);

    state_t          state, state_nxt;
    logic [AW:0]     cnt, cnt_nxt;
    logic            clr_active;
    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy, busy_nxt;
    logic            wr_ok, issue_ok;
    logic            hit1, hit2;
    logic            rd1_ok, rd2_ok;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && (32'(a) < NREGS);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        ready      = (state == RUN);
        clr_active = (state == CLEAR);
    end

    assign wr_ok    = ready && wr_en && addr_ok(wr_addr);
    assign issue_ok = ready && issue_en && addr_ok(issue_rd);

    // The array has no reset of its own; the sweep is the only thing that zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_active)
                regs[cnt[AW-1:0]] <= '0;
            else if (wr_ok)
                regs[wr_addr] <= wr_data;
        end
    end

    // Issue beats a same-cycle writeback to the same register; flush beats both.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (issue_ok && issue_rd == i[AW-1:0])
                    busy_nxt[i] = 1'b1;
                else if (wr_ok && wr_addr == i[AW-1:0])
                    busy_nxt[i] = 1'b0;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst || !ready)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    assign rd1_ok = ready && addr_ok(rs1_addr);
    assign rd2_ok = ready && addr_ok(rs2_addr);
    assign hit1   = (BYPASS != 0) && wr_ok && (wr_addr == rs1_addr);
    assign hit2   = (BYPASS != 0) && wr_ok && (wr_addr == rs2_addr);

    assign rs1_data = rd1_ok ? (hit1 ? wr_data : regs[rs1_addr]) : '0;
    assign rs2_data = rd2_ok ? (hit2 ? wr_data : regs[rs2_addr]) : '0;
    assign rs1_busy = rd1_ok && busy[rs1_addr] && !hit1;
    assign rs2_busy = rd2_ok && busy[rs2_addr] && !hit2;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one bypassing and one non-bypassing instance share all inputs.
module tb_regfile_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   rs1_addr, rs2_addr, wr_addr, issue_rd;
    logic [XLEN-1:0] wr_data;
    logic            wr_en, issue_en, flush;

    logic [XLEN-1:0] rs1_data, rs2_data, nb_rs1_data, nb_rs2_data;
    logic            rs1_busy, rs2_busy, nb_rs1_busy, nb_rs2_busy;
    logic            ready, nb_ready;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .BYPASS(1)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .flush(flush), .ready(ready)
    );

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data),
        .rs1_busy(nb_rs1_busy), .rs2_busy(nb_rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .flush(flush), .ready(nb_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wr_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
        wr_addr = '0; wr_data = '0; issue_rd = '0;
    endtask

    // Counts edges from reset release until ready; a missing ready yields a bounded, wrong count.
    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 4 * NREGS) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        int n;
        int bad;
        idle();
        rs1_addr = '0; rs2_addr = '0;
        rst = 1'b1;
        tick();
        total_cnt++;
        if (ready !== 1'b0) $display("FAIL reset_ready_low: got %b want 0", ready);
        else pass_cnt++;
        rst = 1'b0;
        wait_ready(n);
        total_cnt++;
        if (n !== NREGS) $display("FAIL reset_sweep_len: got %0d want %0d", n, NREGS);
        else pass_cnt++;
        total_cnt++;
        if (nb_ready !== 1'b1) $display("FAIL reset_nb_ready: got %b want 1", nb_ready);
        else pass_cnt++;
        bad = 0;
        for (int a = 0; a < NREGS; a++) begin
            rs1_addr = AW'(a); rs2_addr = AW'(a);
            #1;
            if (rs1_data !== '0 || rs2_data !== '0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL reset_all_zero: got %0d bad entries want 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_write_read;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        rs1_addr = 5'd9; rs2_addr = 5'd9;
        tick();
        idle();
        rs1_addr = 5'd5; rs2_addr = 5'd5;
        #1;
        total_cnt++;
        if (rs1_data !== 32'hDEADBEEF) $display("FAIL wr_rd_rs1: got %h want deadbeef", rs1_data);
        else pass_cnt++;
        total_cnt++;
        if (rs2_data !== 32'hDEADBEEF) $display("FAIL wr_rd_rs2: got %h want deadbeef", rs2_data);
        else pass_cnt++;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        rs1_addr = 5'd0;
        #1;
        total_cnt++;
        if (rs1_data !== '0) $display("FAIL x0_no_bypass: got %h want 0", rs1_data);
        else pass_cnt++;
        tick();
        idle();
        #1;
        total_cnt++;
        if (rs1_data !== '0) $display("FAIL x0_read: got %h want 0", rs1_data);
        else pass_cnt++;
    endtask

    task automatic test_bypass;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        rs1_addr = 5'd7;
        #1;
        total_cnt++;
        if (rs1_data !== 32'hA5A5A5A5) $display("FAIL bypass_same_cycle: got %h want a5a5a5a5", rs1_data);
        else pass_cnt++;
        total_cnt++;
        if (nb_rs1_data !== 32'h0) $display("FAIL nobypass_old: got %h want 0", nb_rs1_data);
        else pass_cnt++;
        tick();
        idle();
        #1;
        total_cnt++;
        if (nb_rs1_data !== 32'hA5A5A5A5) $display("FAIL nobypass_next: got %h want a5a5a5a5", nb_rs1_data);
        else pass_cnt++;
    endtask

    task automatic test_scoreboard;
        issue_en = 1'b1; issue_rd = 5'd3;
        tick();
        idle();
        rs1_addr = 5'd3; rs2_addr = 5'd3;
        #1;
        total_cnt++;
        if (rs2_busy !== 1'b1 || rs1_busy !== 1'b1)
            $display("FAIL sb_issue_set: got rs1=%b rs2=%b want 1 1", rs1_busy, rs2_busy);
        else pass_cnt++;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        #1;
        total_cnt++;
        if (rs2_busy !== 1'b0 || nb_rs2_busy !== 1'b1)
            $display("FAIL sb_wb_bypass: got byp=%b nobyp=%b want 0 1", rs2_busy, nb_rs2_busy);
        else pass_cnt++;
        tick();
        idle();
        #1;
        total_cnt++;
        if (rs2_busy !== 1'b0 || nb_rs2_busy !== 1'b0)
            $display("FAIL sb_wb_clear: got byp=%b nobyp=%b want 0 0", rs2_busy, nb_rs2_busy);
        else pass_cnt++;
        issue_en = 1'b1; issue_rd = 5'd3;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h44;
        tick();
        idle();
        #1;
        total_cnt++;
        if (rs2_busy !== 1'b1 || nb_rs2_busy !== 1'b1)
            $display("FAIL sb_set_wins: got byp=%b nobyp=%b want 1 1", rs2_busy, nb_rs2_busy);
        else pass_cnt++;
        issue_en = 1'b1; issue_rd = 5'd0;
        tick();
        idle();
        rs1_addr = 5'd0;
        #1;
        total_cnt++;
        if (rs1_busy !== 1'b0) $display("FAIL sb_x0_never_busy: got %b want 0", rs1_busy);
        else pass_cnt++;
    endtask

    task automatic test_flush;
        int bad;
        issue_en = 1'b1;
        issue_rd = 5'd1; tick();
        issue_rd = 5'd2; tick();
        issue_rd = 5'd4; tick();
        idle();
        rs1_addr = 5'd4; rs2_addr = 5'd1;
        #1;
        total_cnt++;
        if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1)
            $display("FAIL flush_pre_busy: got x4=%b x1=%b want 1 1", rs1_busy, rs2_busy);
        else pass_cnt++;
        flush = 1'b1; issue_en = 1'b1; issue_rd = 5'd6;
        tick();
        idle();
        bad = 0;
        for (int a = 0; a < NREGS; a++) begin
            rs1_addr = AW'(a); rs2_addr = AW'(a);
            #1;
            if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || nb_rs1_busy !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL flush_all_clear: got %0d busy entries want 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset;
        int n;
        rst = 1'b1;
        tick();
        total_cnt++;
        if (ready !== 1'b0) $display("FAIL run_reset_ready: got %b want 0", ready);
        else pass_cnt++;
        rst = 1'b0;
        repeat (10) tick();
        total_cnt++;
        if (ready !== 1'b0) $display("FAIL mid_sweep_ready: got %b want 0", ready);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFFFFFF;
        issue_en = 1'b1; issue_rd = 5'd9;
        rs1_addr = 5'd5; rs2_addr = 5'd9;
        #1;
        total_cnt++;
        if (rs1_data !== '0 || rs2_busy !== 1'b0)
            $display("FAIL clear_outputs_zero: got data=%h busy=%b want 0 0", rs1_data, rs2_busy);
        else pass_cnt++;
        wait_ready(n);
        idle();
        #1;
        total_cnt++;
        if (n !== NREGS) $display("FAIL restart_sweep_len: got %0d want %0d", n, NREGS);
        else pass_cnt++;
        total_cnt++;
        if (rs1_data !== '0) $display("FAIL clear_write_ignored: got %h want 0", rs1_data);
        else pass_cnt++;
        total_cnt++;
        if (rs2_busy !== 1'b0) $display("FAIL clear_issue_ignored: got %b want 0", rs2_busy);
        else pass_cnt++;
        rs1_addr = 5'd7;
        #1;
        total_cnt++;
        if (rs1_data !== '0) $display("FAIL sweep_cleared_x7: got %h want 0", rs1_data);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rs1_addr = '0; rs2_addr = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_flush();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
